// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types and width helpers for the sequential square-root core
package sqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } sqrt_state_t;

    localparam int MODE_LINEAR = 0;
    localparam int MODE_DIGIT  = 1;

    // Integer root of a w-bit radicand needs w/2 bits.
    function automatic int root_width(input int w);
        return w / 2;
    endfunction

    // Remainder is at most 2*root, so one bit more than the root.
    function automatic int rem_width(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/sqrt_en_reg.sv
// rtl/sqrt_en_reg.sv - width-parametrised register with load enable and synchronous clear
module sqrt_en_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over load; otherwise hold.
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/sqrt_seq_core.sv
// rtl/sqrt_seq_core.sv - sequential integer square root with selectable linear or digit-by-digit datapath
module sqrt_seq_core
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem,
    output logic               busy
);

    localparam int HW = root_width(WIDTH);
    localparam int RW = rem_width(WIDTH);

    sqrt_state_t      state, state_nxt;
    logic             accept, step, fin;
    logic [WIDTH-1:0] a_reg;
    logic             dp_fin;
    logic [HW-1:0]    dp_root;
    logic [RW-1:0]    dp_rem;

    assign accept = (state == S_IDLE) && in_valid;
    assign step   = (state == S_CALC);
    assign fin    = step && dp_fin;

    // State register.
    always_ff @(posedge clk) begin
        if (clr)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: IDLE accepts, CALC runs until the datapath finishes, DONE waits for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)  state_nxt = S_CALC;
            S_CALC:  if (dp_fin)    state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state alone.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready  = 1'b1;
            S_CALC:  busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    sqrt_en_reg #(.W(WIDTH)) u_a_reg (
        .clk (clk), .clr (clr), .en (accept), .d (a), .q (a_reg)
    );

    sqrt_en_reg #(.W(HW)) u_root_reg (
        .clk (clk), .clr (clr), .en (fin), .d (dp_root), .q (root)
    );

    sqrt_en_reg #(.W(RW)) u_rem_reg (
        .clk (clk), .clr (clr), .en (fin), .d (dp_rem), .q (rem)
    );

    generate
        if (MODE == MODE_LINEAR) begin : g_linear
            // sq tracks (cnt+1)^2 by adding successive odd numbers held in del.
            logic [WIDTH:0] sq;
            logic [HW+1:0]  del;
            logic [HW-1:0]  cnt;
            logic [WIDTH-1:0] cnt_w;

            // Finish as soon as the next square overshoots the radicand.
            always_comb begin
                cnt_w   = WIDTH'(cnt);
                dp_fin  = sq > {1'b0, a_reg};
                dp_root = cnt;
                dp_rem  = RW'(a_reg - cnt_w * cnt_w);
            end

            // Accumulate one odd number per CALC cycle.
            always_ff @(posedge clk) begin
                if (clr) begin
                    sq  <= '0;
                    del <= '0;
                    cnt <= '0;
                end else if (accept) begin
                    sq  <= (WIDTH+1)'(1);
                    del <= (HW+2)'(3);
                    cnt <= '0;
                end else if (step && !dp_fin) begin
                    sq  <= sq + (WIDTH+1)'(del);
                    del <= del + (HW+2)'(2);
                    cnt <= cnt + HW'(1);
                end
            end
        end else begin : g_digit
            localparam int CW = $clog2(HW) + 1;
            logic [CW-1:0] iter;
            logic [CW-1:0] pos;
            logic [HW-1:0] q;
            logic [HW:0]   r;
            logic [1:0]    pair;
            logic [HW+2:0] cur, sub;
            logic          ge;
            logic [HW:0]   diff;

            // Bring down the next bit pair (MSB first) and try subtracting 4q+1.
            always_comb begin
                pos     = CW'(HW - 1) - iter;
                pair    = 2'(a_reg >> {pos, 1'b0});
                cur     = {r, pair};
                sub     = {1'b0, q, 2'b01};
                ge      = cur >= sub;
                diff    = (HW+1)'(ge ? cur - sub : cur);
                dp_root = HW'({q, ge});
                dp_rem  = diff;
                dp_fin  = (iter == CW'(HW - 1));
            end

            // One root bit per CALC cycle; the last step's result goes straight to the output registers.
            always_ff @(posedge clk) begin
                if (clr) begin
                    iter <= '0;
                    q    <= '0;
                    r    <= '0;
                end else if (accept) begin
                    iter <= '0;
                    q    <= '0;
                    r    <= '0;
                end else if (step && !dp_fin) begin
                    iter <= iter + CW'(1);
                    q    <= dp_root;
                    r    <= diff;
                end
            end
        end
    endgenerate

endmodule
